scurve_scan_ctrl: RTL
=====================

// Module: scurve_scan_ctrl
// PURPOSE
//  Upstream sequencer for the Microroc top: automated S-curve threshold scan. Steps the DAC0 threshold
//  from StartDac to EndDac, reloads slow control per point, counts OUT_TRIG0B falling edges over a
//  programmable window, and writes (DAC, count) pairs framed by a header/trailer into the USB FIFO.
// PARAMETERS
//  DAC_W          10    threshold DAC width (Microroc DAC0_Vth)
//  CNT_W          16    trigger counter width = FIFO word width
//  SETTLE_CYCLES  400   Clk cycles waited after Config_Done before counting (10 us @ 40 MHz)
//  HEADER_WORD    16'h5343  first word of a scan
//  TRAILER_WORD   16'hFF45  last word of a scan
// PORTS
//  Clk            in   1      40 MHz system clock
//  reset          in   1      asynchronous reset, active-high
//  Scan_start     in   1      1-cycle pulse, starts a scan when idle
//  Scan_abort     in   1      level/pulse, aborts a running scan
//  StartDac       in   DAC_W  first threshold code
//  EndDac         in   DAC_W  last threshold code (inclusive)
//  DacStep        in   DAC_W  threshold increment; 0 treated as 1
//  CountTime      in   16     count window in Clk cycles; 0 treated as 1
//  Config_Done    in   1      slow-control load complete (level)
//  OUT_TRIG0B     in   1      Microroc trigger, active-low, asynchronous
//  ext_fifo_full  in   1      USB FIFO full
//  DAC0_Vth       out  DAC_W  threshold driven to slow control
//  Sc_start_load  out  1      1-cycle pulse, launches slow-control load
//  Scan_data      out  CNT_W  FIFO write data
//  Scan_data_en   out  1      FIFO write strobe
//  Scan_busy      out  1      high from accepted Scan_start until return to IDLE
//  Scan_done      out  1      1-cycle pulse after trailer written
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters cleared; reset mid-scan discards the scan (no trailer).
//  - States: IDLE -> HDR -> LOAD -> WAITCFG -> SETTLE -> COUNT -> WR_DAC -> WR_CNT -> NEXT -> (LOAD|TAIL) -> IDLE.
//  - IDLE: Scan_start latches StartDac/EndDac/DacStep/CountTime into shadow regs; DAC0_Vth<=StartDac.
//    Scan_start while busy ignored. Inputs changed mid-scan have no effect.
//  - HDR: write HEADER_WORD. If StartDac>EndDac go directly to TAIL (header+trailer only).
//  - LOAD: Sc_start_load high exactly 1 cycle; DAC0_Vth stable from >=1 cycle before, held through point.
//  - WAITCFG: wait for Config_Done 0->1 transition (edge-detected, registered); no timeout.
//  - SETTLE: exactly SETTLE_CYCLES cycles; trigger edges ignored.
//  - COUNT: exactly CountTime cycles; counter cleared on entry; each synchronised falling edge of
//    OUT_TRIG0B (2-FF sync + edge detect, 3-cycle latency) in-window adds 1; saturates at 2^CNT_W-1.
//  - FIFO handshake (HDR, WR_DAC, WR_CNT, TAIL): Scan_data_en=1 only in a cycle with ext_fifo_full=0;
//    that word is written and FSM advances. While full: strobe 0, Scan_data held, FSM waits.
//  - WR_DAC word = {zero-pad, DAC0_Vth}; WR_CNT word = count.
//  - NEXT: sum = DAC0_Vth + step computed DAC_W+1 wide; if DAC0_Vth==EndDac or sum>EndDac
//    (incl. sum>2^DAC_W-1) -> TAIL, else DAC0_Vth<=sum[DAC_W-1:0] -> LOAD. No wrap-around ever.
//  - TAIL: write TRAILER_WORD; Scan_done pulses 1 cycle in the cycle after the write; Scan_busy falls with it.
//  - Scan_abort: from any non-IDLE state, next cycle IDLE, Scan_busy=0, no further words, no Scan_done;
//    a strobe in the abort cycle is still valid (word counted as written). DAC0_Vth keeps last value.
//  - Scan_start and Scan_abort same cycle in IDLE: abort wins, scan not started.
// TESTING
//  1 Start=100 End=102 Step=1 CountTime=1000, trig period 10 cycles -> FIFO: 5343,0064,0064,0065,0064,
//    0066,0064,FF45; 3 Sc_start_load pulses; one Scan_done.
//  2 ext_fifo_full high 50 cycles entering WR_CNT -> Scan_data_en=0 throughout, Scan_data stable, same
//    word written once after full drops; no duplicate/lost words.
//  3 Start=1020 End=1023 Step=2 -> DAC points 1020,1022 only, then FF45; DAC0_Vth never wraps.
//  4 Start=500 End=400 -> FIFO gets exactly 5343,FF45; no Sc_start_load pulse.
//  5 CountTime=65535, trig period 2 cycles (~32767 edges), then repeat with 70000-edge window via
//    CNT_W=16 forced saturation -> count word FFFF, no rollover.
//  6 Scan_abort / reset asserted mid-COUNT -> next cycle Scan_busy=0, no further strobes, no Scan_done;
//    reset case: all outputs 0; new Scan_start then runs a clean scan from HDR.

Source files
------------

// File: rtl/scurve_scan_ctrl.sv
// scurve_scan_ctrl: S-curve threshold scan sequencer; steps DAC0 threshold, reloads slow control,
// counts OUT_TRIG0B falling edges per point and streams framed (DAC, count) pairs into the USB FIFO.
module scurve_scan_ctrl #(
   parameter int DAC_W = 10,
   parameter int CNT_W = 16,
   parameter int SETTLE_CYCLES = 400,
   parameter logic [CNT_W-1:0] HEADER_WORD = CNT_W'(16'h5343),
   parameter logic [CNT_W-1:0] TRAILER_WORD = CNT_W'(16'hFF45)
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             Scan_start,
   input  logic             Scan_abort,
   input  logic [DAC_W-1:0] StartDac,
   input  logic [DAC_W-1:0] EndDac,
   input  logic [DAC_W-1:0] DacStep,
   input  logic [15:0]      CountTime,
   input  logic             Config_Done,
   input  logic             OUT_TRIG0B,
   input  logic             ext_fifo_full,
   output logic [DAC_W-1:0] DAC0_Vth,
   output logic             Sc_start_load,
   output logic [CNT_W-1:0] Scan_data,
   output logic             Scan_data_en,
   output logic             Scan_busy,
   output logic             Scan_done
);
   localparam int TW = ($clog2(SETTLE_CYCLES + 1) > 16) ? $clog2(SETTLE_CYCLES + 1) : 16;
   typedef enum logic [3:0] {IDLE, HDR, LOAD, WAITCFG, SETTLE, COUNT, WR_DAC, WR_CNT, NEXT, TAIL} state_t;
   state_t state, next;
   logic [DAC_W-1:0] end_q, step_q;
   logic [15:0] ct_q;
   logic [TW-1:0] timer;
   logic [CNT_W-1:0] count;
   logic [1:0] cfg_q;
   logic [2:0] trig_q;
   logic [DAC_W:0] sum;
   logic cfg_rise, trig_fall, fire, at_end, accept, last_settle, last_count;

   assign cfg_rise = cfg_q[0] & ~cfg_q[1];
   assign trig_fall = trig_q[2] & ~trig_q[1];
   // one extra bit so a step past the top code can never wrap back into range
   assign sum = {1'b0, DAC0_Vth} + {1'b0, step_q};
   assign at_end = (DAC0_Vth == end_q) || (sum > {1'b0, end_q});
   assign accept = (state == IDLE) && Scan_start && !Scan_abort;
   assign fire = (state inside {HDR, WR_DAC, WR_CNT, TAIL}) && !ext_fifo_full;
   assign last_settle = timer == TW'(SETTLE_CYCLES - 1);
   assign last_count = timer == TW'(ct_q - 16'd1);

   always_ff @(posedge Clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;

   always_comb begin
      next = state;
      Sc_start_load = state == LOAD;
      Scan_busy = state != IDLE;
      Scan_data_en = fire;
      Scan_data = (state == HDR) ? HEADER_WORD :
                  (state == WR_DAC) ? CNT_W'(DAC0_Vth) :
                  (state == WR_CNT) ? count :
                  (state == TAIL) ? TRAILER_WORD : '0;
      case (state)
         IDLE:    next = accept ? HDR : IDLE;
         HDR:     next = !fire ? HDR : (DAC0_Vth > end_q) ? TAIL : LOAD;
         LOAD:    next = WAITCFG;
         WAITCFG: next = cfg_rise ? SETTLE : WAITCFG;
         SETTLE:  next = last_settle ? COUNT : SETTLE;
         COUNT:   next = last_count ? WR_DAC : COUNT;
         WR_DAC:  next = fire ? WR_CNT : WR_DAC;
         WR_CNT:  next = fire ? NEXT : WR_CNT;
         NEXT:    next = at_end ? TAIL : LOAD;
         TAIL:    next = fire ? IDLE : TAIL;
         default: next = IDLE;
      endcase
      if (Scan_abort && state != IDLE) next = IDLE;
   end

   always_ff @(posedge Clk or posedge reset)
      if (reset) begin
         DAC0_Vth <= '0;
         end_q <= '0;
         step_q <= '0;
         ct_q <= '0;
         timer <= '0;
         count <= '0;
         cfg_q <= '0;
         trig_q <= '1;
         Scan_done <= 1'b0;
      end else begin
         cfg_q <= {cfg_q[0], Config_Done};
         trig_q <= {trig_q[1:0], OUT_TRIG0B};
         Scan_done <= (state == TAIL) && fire && !Scan_abort;
         timer <= (next != state || state == IDLE) ? '0 : timer + 1'b1;
         if (accept) begin
            DAC0_Vth <= StartDac;
            end_q <= EndDac;
            step_q <= (DacStep == '0) ? DAC_W'(1) : DacStep;
            ct_q <= (CountTime == 16'd0) ? 16'd1 : CountTime;
         end
         if (state == NEXT && !at_end && !Scan_abort) DAC0_Vth <= sum[DAC_W-1:0];
         if (state == SETTLE) count <= '0;
         else if (state == COUNT && trig_fall && count != '1) count <= count + 1'b1;
      end
endmodule
